fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Sits directly downstream of the PC generator.
- Takes the current PC, issues in-order instruction-memory read requests, and buffers returned instructions with their PCs in a small slot-reserving FIFO.
- Presents buffered instructions to decode over a valid/ready handshake.
- Drives the PC stall back to the PC generator and discards in-flight fetches on a redirect flush.

Parameters:
- DEPTH, 4, number of buffer slots; power of two, >= 2.
- XLEN, 32, address and instruction width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- pc  input  XLEN  current fetch PC from the PC generator.
- stall_pc  output  1  holds the PC generator; high when no request is accepted this cycle.
- flush  input  1  redirect; drops all buffered and outstanding fetches.
- imem_req  output  1  memory read request.
- imem_addr  output  XLEN  request address; always equals pc.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; responses return in order, at least 1 cycle after the grant.
- imem_rdata  input  XLEN  instruction data.
- id_valid  output  1  instruction available to decode.
- id_pc  output  XLEN  PC of the head instruction.
- id_instr  output  XLEN  head instruction.
- id_ready  input  1  decode accepts the head instruction.

Behaviour:
- **Reset.** On i_rst, the next edge clears all slot-valid and filled bits, head/tail/fill pointers, count and drop_cnt.
  - While i_rst is high: id_valid=0, imem_req=0, stall_pc=1.
- **Slots.** Each slot holds {pc, instr, filled}.
  - count = number of allocated slots.
  - drop_cnt (width clog2(DEPTH)+1) = number of pre-flush responses still to be discarded.
- **Request issue** (combinational): imem_req = !i_rst && !flush && (count < DEPTH).
  - accept = imem_req && imem_gnt.
  - stall_pc = !flush && !accept. During flush stall_pc=0, so the PC generator takes its redirect.
- **Allocate.** On accept, write pc to the tail slot with filled=0; tail++, count++.
- **Fill.** On imem_rvalid:
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise write imem_rdata into the oldest unfilled slot, set filled=1, fill pointer++.
  - rvalid with no unfilled slot and drop_cnt==0 is a protocol violation. The data is ignored and an assertion fires.
- **Output.** id_valid = (count > 0) && head.filled; id_pc and id_instr come from the head slot.
  - On id_valid && id_ready: head++, count--.
  - While id_valid && !id_ready, outputs are held stable.
- **Latency.**
  - Grant in cycle N, rvalid in cycle N+k (k >= 1), id_valid in cycle N+k+1. There is no rvalid-to-decode bypass.
  - Back-to-back throughput is 1 instruction/cycle.
- **Simultaneous allocate and pop.** Count is unchanged.
  - When count==DEPTH, a pop in that cycle does not enable imem_req in the same cycle. The request resumes the following cycle.
- **Flush (registered on the edge):**
  - All slots are cleared and pointers reset.
  - drop_cnt <= drop_cnt + unfilled_allocated − (imem_rvalid ? 1 : 0), saturating at 0. An rvalid in the flush cycle is always discarded.
  - No allocate or pop occurs in the flush cycle; id_valid is ignored by decode.
  - New requests may issue from the next cycle while drop_cnt > 0. In-order return guarantees the first drop_cnt responses are the stale ones.
- **Wrap-around.** Pointers wrap modulo DEPTH. Full and empty are determined by count, not by pointer equality.
- **Reset mid-operation.** Identical to power-up reset. Any outstanding responses arriving after reset are the memory's responsibility (the memory is reset by the same i_rst).

Test Plan:
1. Streaming.
   - Stimulus: after reset pc=0; imem_gnt=1 always; rvalid 1 cycle after each grant with rdata = addr ^ 32'hA5A5_0000; id_ready=1.
   - Response: first id_valid 2 cycles after the first grant with id_pc=0, id_instr=0xA5A50000. Then id_pc 0x4, 0x8, 0xC on consecutive cycles; stall_pc=0 throughout.
2. Backpressure.
   - Stimulus: id_ready=0.
   - Response: after 4 grants, imem_req=0 and stall_pc=1, with id_pc=0 held stable. On id_ready=1, the buffer drains 0x0, 0x4, 0x8, 0xC in order; imem_req returns the cycle after the first pop.
3. Grant stall.
   - Stimulus: imem_gnt=0 for 3 cycles at pc=0x10.
   - Response: imem_req=1, imem_addr=0x10, stall_pc=1 for all 3 cycles; no slot allocated.
4. Flush with outstanding requests.
   - Stimulus: 2 requests granted, responses delayed 3 cycles; flush pulses; PC generator redirects to 0x100.
   - Response: the 2 stale rvalids are discarded (drop_cnt 2→1→0). The first id_valid carries id_pc=0x100 with its correct instruction.
5. Flush coincident with rvalid and a full buffer.
   - Response: count=0 and id_valid=0 the next cycle; drop_cnt equals unfilled slots minus 1.
6. Reset mid-stream.
   - Stimulus: assert i_rst with 3 slots filled.
   - Response: next cycle id_valid=0, imem_req=0, stall_pc=1. After deassert, fetch restarts at pc=0.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues in-order imem reads at the current PC and queues
// the returned instructions with their PCs for decode over a valid/ready handshake.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] pc,
    output logic            stall_pc,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    input  logic            id_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshakes: imem accepts a request when imem_req && imem_gnt in the same cycle;
    // decode takes the head entry when id_valid && id_ready; rvalid needs no handshake.
    logic [XLEN-1:0] slot_pc_q    [DEPTH];
    logic [XLEN-1:0] slot_instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    fill_q, fill_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    unfilled_q, unfilled_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
    logic [CW:0]      drop_sum;

    logic full;
    logic accept;
    logic pop;
    logic drop_hit;
    logic fill_en;

    assign full      = (count_q == CW'(DEPTH));
    assign imem_req  = !i_rst && !flush && !full;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;
    assign stall_pc  = i_rst || (!flush && !accept);

    assign id_valid  = !i_rst && (count_q != '0) && filled_q[head_q];
    assign id_pc     = slot_pc_q[head_q];
    assign id_instr  = slot_instr_q[head_q];
    assign pop       = id_valid && id_ready && !flush;

    assign drop_hit  = imem_rvalid && !flush && (drop_cnt_q != '0);
    assign fill_en   = imem_rvalid && !flush && !i_rst && (drop_cnt_q == '0) && (unfilled_q != '0);

    always_comb begin
        filled_d   = filled_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        unfilled_d = unfilled_q;
        drop_cnt_d = drop_cnt_q;
        drop_sum   = {1'b0, drop_cnt_q} + {1'b0, unfilled_q};

        if (flush) begin
            // Every unfilled slot still has a response in flight; the one arriving now is dropped too.
            if (imem_rvalid && (drop_sum != '0)) begin
                drop_sum = drop_sum - 1'b1;
            end
            drop_cnt_d = drop_sum[CW] ? '1 : drop_sum[CW-1:0];
            filled_d   = '0;
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            unfilled_d = '0;
        end else begin
            if (accept) begin
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + PW'(1);
            end
            if (fill_en) begin
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (drop_hit) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            count_d    = count_q + CW'(accept) - CW'(pop);
            unfilled_d = unfilled_q + CW'(accept) - CW'(fill_en);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            filled_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            filled_q   <= filled_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            unfilled_q <= unfilled_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in filled_q/count_q.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            slot_pc_q[tail_q] <= pc;
        end
        if (fill_en) begin
            slot_instr_q[fill_q] <= imem_rdata;
        end
    end

    rvalid_has_target: assert property (@(posedge i_clk) disable iff (i_rst)
        (imem_rvalid && !flush) |-> ((drop_cnt_q != '0) || (unfilled_q != '0)));

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: queue-based buffer model plus an in-order memory model.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [XLEN-1:0] pc;
  logic            stall_pc;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            id_ready;

  always #5 i_clk = ~i_clk;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .pc          (pc),
    .stall_pc    (stall_pc),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_ready    (id_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  ent_t        mdl_q[$];
  mreq_t       mem_q[$];
  int          drop_m;
  logic [31:0] pc_m;
  int          cyc;

  bit          rst_k;
  bit          flush_k;
  logic [31:0] redirect_k;
  int          gnt_pct;
  int          ready_pct;
  int          lat_min;
  int          lat_max;

  logic        obs_req, obs_stall, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr;
  bit          last_acc;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  // One clock cycle: drive, settle, compare against the model, advance the model.
  task automatic run_cycle();
    bit          rv;
    bit          exp_req, acc, exp_stall, exp_valid, found;
    int          unf;
    logic [31:0] rv_addr;

    rv      = !rst_k && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rv_addr = rv ? mem_q[0].addr : 32'h0;
    i_rst       = rst_k;
    flush       = flush_k;
    pc          = pc_m;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    id_ready    = ($urandom_range(99) < ready_pct);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_data(rv_addr) : $urandom;
    #1;
    obs_req   = imem_req;
    obs_stall = stall_pc;
    obs_valid = id_valid;
    obs_addr  = imem_addr;
    obs_pc    = id_pc;
    obs_instr = id_instr;

    exp_req   = !rst_k && !flush_k && (mdl_q.size() < DEPTH);
    acc       = exp_req && imem_gnt;
    exp_stall = rst_k || (!flush_k && !acc);
    exp_valid = !rst_k && (mdl_q.size() > 0) && mdl_q[0].filled;
    last_acc  = acc;

    check("imem_req", 32'(obs_req), 32'(exp_req));
    check("stall_pc", 32'(obs_stall), 32'(exp_stall));
    check("id_valid", 32'(obs_valid), 32'(exp_valid));
    check("imem_addr", obs_addr, pc_m);
    if (exp_valid) begin
      check("id_pc", obs_pc, mdl_q[0].pc);
      check("id_instr", obs_instr, mdl_q[0].instr);
    end

    if (rst_k) begin
      mdl_q.delete();
      mem_q.delete();
      drop_m = 0;
      pc_m   = 32'h0;
    end else begin
      if (rv) void'(mem_q.pop_front());
      if (flush_k) begin
        unf = 0;
        foreach (mdl_q[i]) if (!mdl_q[i].filled) unf++;
        drop_m = drop_m + unf - (rv ? 1 : 0);
        if (drop_m < 0) drop_m = 0;
        mdl_q.delete();
        pc_m = redirect_k;
      end else begin
        if (rv) begin
          if (drop_m > 0) begin
            drop_m--;
          end else begin
            found = 1'b0;
            for (int i = 0; i < mdl_q.size(); i++) begin
              if (!found && !mdl_q[i].filled) begin
                mdl_q[i].instr  = mem_data(rv_addr);
                mdl_q[i].filled = 1'b1;
                found = 1'b1;
              end
            end
          end
        end
        if (exp_valid && id_ready) void'(mdl_q.pop_front());
        if (acc) begin
          mdl_q.push_back('{pc: pc_m, instr: 32'h0, filled: 1'b0});
          mem_q.push_back('{addr: pc_m, due: cyc + $urandom_range(lat_max, lat_min)});
        end
        if (!exp_stall) pc_m = pc_m + 32'd4;
      end
    end

    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_k   = 1'b1;
    flush_k = 1'b0;
    repeat (n) run_cycle();
    rst_k = 1'b0;
  endtask

  task automatic set_knobs(input int g, input int r, input int lmin, input int lmax);
    gnt_pct   = g;
    ready_pct = r;
    lat_min   = lmin;
    lat_max   = lmax;
  endtask

  int          first_grant, first_valid, n_stall, n_pop, n_seen;
  logic [31:0] pop_pcs[4];
  bit          seen;
  logic [31:0] seen_pc, seen_instr;

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_k = 1'b1; flush_k = 1'b0; redirect_k = 32'h0;
    pc_m = 32'h0; drop_m = 0;
    set_knobs(100, 100, 1, 1);
    i_rst = 1'b1; flush = 1'b0; pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    @(posedge i_clk);
    #1;

    // Streaming: one grant per cycle, 1-cycle memory, decode always ready.
    do_reset(2);
    set_knobs(100, 100, 1, 1);
    first_grant = -1; first_valid = -1; n_stall = 0; n_pop = 0;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      if (obs_stall) n_stall++;
      if (first_grant < 0 && obs_req && imem_gnt) first_grant = cyc - 1;
      if (first_valid < 0 && obs_valid) first_valid = cyc - 1;
      if (obs_valid && n_pop < 4) begin
        pop_pcs[n_pop] = obs_pc;
        n_pop++;
      end
    end
    check("stream_latency", 32'(first_valid - first_grant), 32'd2);
    check("stream_stall_cycles", 32'(n_stall), 32'd0);
    check("stream_pops", 32'(n_pop), 32'd4);
    for (int i = 0; i < 4; i++) check("stream_pc_order", pop_pcs[i], 32'(4 * i));

    // Backpressure: buffer fills, requests stop, head held; then drains.
    do_reset(1);
    set_knobs(100, 0, 1, 1);
    repeat (6) run_cycle();
    check("bp_req_full", 32'(obs_req), 32'd0);
    check("bp_stall_full", 32'(obs_stall), 32'd1);
    check("bp_head_pc", obs_pc, 32'h0);
    check("bp_head_instr", obs_instr, 32'hA5A5_0000);
    set_knobs(100, 100, 1, 1);
    run_cycle();
    check("bp_req_pop_cycle", 32'(obs_req), 32'd0);
    run_cycle();
    check("bp_req_after_pop", 32'(obs_req), 32'd1);
    repeat (6) run_cycle();

    // Grant stall at pc=0x10.
    do_reset(1);
    set_knobs(100, 100, 1, 1);
    repeat (4) run_cycle();
    set_knobs(0, 100, 1, 1);
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("gs_req", 32'(obs_req), 32'd1);
      check("gs_addr", obs_addr, 32'h10);
      check("gs_stall", 32'(obs_stall), 32'd1);
    end
    set_knobs(100, 100, 1, 1);
    repeat (4) run_cycle();

    // Flush with two outstanding slow requests, redirect to 0x100.
    do_reset(1);
    set_knobs(100, 100, 3, 3);
    repeat (2) run_cycle();
    set_knobs(0, 100, 3, 3);
    flush_k = 1'b1; redirect_k = 32'h100;
    run_cycle();
    check("fl_stall_in_flush", 32'(obs_stall), 32'd0);
    flush_k = 1'b0;
    set_knobs(100, 100, 3, 3);
    seen = 1'b0; seen_pc = '0; seen_instr = '0;
    for (int i = 0; i < 15; i++) begin
      run_cycle();
      if (!seen && obs_valid) begin
        seen = 1'b1; seen_pc = obs_pc; seen_instr = obs_instr;
      end
    end
    check("fl_first_valid_seen", 32'(seen), 32'd1);
    check("fl_first_pc", seen_pc, 32'h100);
    check("fl_first_instr", seen_instr, 32'h100 ^ 32'hA5A5_0000);

    // Flush coincident with an rvalid while the buffer is full.
    do_reset(1);
    set_knobs(100, 0, 3, 3);
    repeat (4) run_cycle();
    flush_k = 1'b1; redirect_k = 32'h200;
    run_cycle();
    flush_k = 1'b0;
    set_knobs(100, 100, 2, 2);
    run_cycle();
    check("fc_valid_after", 32'(obs_valid), 32'd0);
    check("fc_req_after", 32'(obs_req), 32'd1);
    seen = 1'b0; seen_pc = '0;
    for (int i = 0; i < 15; i++) begin
      run_cycle();
      if (!seen && obs_valid) begin
        seen = 1'b1; seen_pc = obs_pc;
      end
    end
    check("fc_first_valid_seen", 32'(seen), 32'd1);
    check("fc_first_pc", seen_pc, 32'h200);

    // Reset mid-stream with three slots filled.
    do_reset(1);
    set_knobs(100, 0, 1, 1);
    repeat (4) run_cycle();
    rst_k = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_cycle();
      check("rs_valid", 32'(obs_valid), 32'd0);
      check("rs_req", 32'(obs_req), 32'd0);
      check("rs_stall", 32'(obs_stall), 32'd1);
    end
    rst_k = 1'b0;
    set_knobs(100, 100, 1, 1);
    run_cycle();
    check("rs_restart_req", 32'(obs_req), 32'd1);
    check("rs_restart_addr", obs_addr, 32'h0);
    repeat (4) run_cycle();

    // Randomized traffic with occasional redirects.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 20), 1, 4);
      flush_k    = (drop_m == 0) && ($urandom_range(99) < 3);
      redirect_k = $urandom & 32'h0000_FFFC;
      run_cycle();
    end
    flush_k = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
